datapath_seq: RTL
=================

DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset (one clock; reset synchronous, active-high).
REQ-002 SHALL have ports: instr_valid  in  1  instruction offered; instr  in  16  instruction word; instr_ready  out  1  sequencer can accept an instruction.
REQ-003 SHALL have ports: alu_result  in  8  datapath ALU result; alu_zero  in  1  ALU zero; alu_carry  in  1  ALU carry.
REQ-004 SHALL have ports: ra_addr  out  4; rb_addr  out  4; alu_opcode  out  3; write_addr  out  4; write_data  out  8; write_en  out  1 (all to datapath).
REQ-005 SHALL have ports: busy  out  1  instruction in flight; done  out  1  one-cycle completion pulse; error  out  1  one-cycle illegal-instruction pulse; halted  out  1  HALT executed; zero_flag  out  1; carry_flag  out  1.

Function
REQ-006 SHALL decode instr[15:12]: 0xxx = ALU op (alu_opcode=instr[14:12], rd=instr[11:8], ra=instr[7:4], rb=instr[3:0]); 1000 = LDI (rd=instr[11:8], imm=instr[7:0]); 1001 = HALT; 1010-1111 = illegal.
REQ-007 SHALL implement FSM states IDLE, READ, EXEC, WB, TRAP, HALT; reset state IDLE.
REQ-008 SHALL assert instr_ready only in IDLE; an instruction is accepted on a cycle with instr_valid && instr_ready, and instr is latched internally that cycle.
REQ-009 SHALL transition on acceptance: ALU op -> READ; LDI -> WB; HALT -> HALT; illegal -> TRAP.
REQ-010 SHALL, for an ALU op accepted in cycle N, drive ra_addr/rb_addr/alu_opcode from the latch in READ (N+1) and hold them through EXEC (N+2) and WB (N+3).
REQ-011 SHALL in EXEC capture alu_result into an 8-bit result register and alu_zero/alu_carry into pending-flag registers.
REQ-012 SHALL in WB assert write_en=1 for exactly one cycle with write_addr=rd and write_data=result register (ALU op) or imm (LDI); done=1 in the same cycle; next state IDLE.
REQ-013 SHALL give latency acceptance-to-write_en of 3 cycles for ALU ops and 1 cycle for LDI; instr_ready returns high the cycle after WB.
REQ-014 SHALL in TRAP pulse error=1 for one cycle, never assert write_en, then return to IDLE.
REQ-015 SHALL in HALT hold halted=1, instr_ready=0, write_en=0 until rst; done and error stay 0.
REQ-016 SHALL drive busy=1 in READ, EXEC, WB, TRAP; 0 in IDLE and HALT.
REQ-017 SHALL keep write_en=0 in every state other than WB; rd=0 is a legal destination (no special case).
REQ-018 SHALL ignore instr and instr_valid in every state other than IDLE; instr changing while busy has no effect.

Reset
REQ-019 SHALL, on rst=1 at a clock edge, enter IDLE and clear all outputs to 0 except instr_ready, which is 1 from the first cycle after reset deasserts.
REQ-020 SHALL abort any in-flight instruction on rst (including in WB): write_en=0 from the next edge, no later write, done, or error for the aborted instruction.
REQ-021 SHALL let rst override instr_valid in the same cycle: no instruction accepted.

Configuration
REQ-022 SHALL support macro DATAPATH_SEQ_FLAGS_EN: when defined, pending flags captured in EXEC are copied to zero_flag/carry_flag in WB (LDI, TRAP, HALT leave them unchanged; reset clears them).
REQ-023 SHALL, when DATAPATH_SEQ_FLAGS_EN is undefined, tie zero_flag and carry_flag to 0 and omit the flag registers.

Verification
REQ-024 SHALL cover LDI: instr=16'h83A5 accepted at N -> write_en=1, write_addr=3, write_data=8'hA5, done=1 at N+1; instr_ready=1 at N+2.
REQ-025 SHALL cover ALU op: instr=16'h2512 accepted at N, alu_result=8'h00, alu_zero=1, alu_carry=1 at N+2 -> ra_addr=1, rb_addr=2, alu_opcode=2 from N+1; write_en=1, write_addr=5, write_data=8'h00 at N+3; with flags macro zero_flag=1, carry_flag=1 from N+4.
REQ-026 SHALL cover illegal: instr=16'hB000 accepted -> error=1 one cycle later for one cycle, write_en never 1, instr_ready=1 the following cycle.
REQ-027 SHALL cover HALT: instr=16'h9000 accepted -> halted=1, instr_ready=0 held for 20 cycles with instr_valid=1; rst -> halted=0, instr_ready=1.
REQ-028 SHALL cover reset mid-op: rst in EXEC of instr=16'h0712 -> no write_en, no done; next LDI 16'h8411 completes normally with write_addr=4, write_data=8'h11.

Source files
------------

// File: rtl/datapath_seq.sv
// Instruction sequencer driving a register-file/ALU datapath: ALU ops, LDI, HALT, illegal trap.
// Optional macro DATAPATH_SEQ_FLAGS_EN adds architectural zero/carry flags updated on ALU writeback.
module datapath_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic [3:0]        ra_addr,
  output logic [3:0]        rb_addr,
  output logic [2:0]        alu_opcode,
  output logic [3:0]        write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              halted,
  output logic              zero_flag,
  output logic              carry_flag
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] EXEC = 3'd2;
  localparam logic [2:0] WB   = 3'd3;
  localparam logic [2:0] TRAP = 3'd4;
  localparam logic [2:0] HALT = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              accept;
  logic              alu_path;
  logic [15:0]       instr_p0;
  logic [DATA_W-1:0] result_p1;

  assign accept = instr_valid && (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          if (!instr[15])                  state_nxt = READ;
          else if (instr[15:12] == 4'b1000) state_nxt = WB;
          else if (instr[15:12] == 4'b1001) state_nxt = HALT;
          else                              state_nxt = TRAP;
        end
      end
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      TRAP:    state_nxt = IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: instruction latch, written only on acceptance
  always_ff @(posedge clk) begin
    if (accept) instr_p0 <= instr;
  end

  // Stage p1: ALU result captured in EXEC
  always_ff @(posedge clk) begin
    if (state == EXEC) result_p1 <= alu_result;
  end

`ifdef DATAPATH_SEQ_FLAGS_EN
  logic zero_pend_p1;
  logic carry_pend_p1;
  logic zero_flag_q;
  logic carry_flag_q;

  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      zero_pend_p1  <= alu_zero;
      carry_pend_p1 <= alu_carry;
    end
  end

  // Only an ALU writeback commits flags; LDI also passes through WB
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag_q  <= 1'b0;
      carry_flag_q <= 1'b0;
    end else if (state == WB && !instr_p0[15]) begin
      zero_flag_q  <= zero_pend_p1;
      carry_flag_q <= carry_pend_p1;
    end
  end

  assign zero_flag  = zero_flag_q;
  assign carry_flag = carry_flag_q;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = alu_zero ^ alu_carry;
  assign zero_flag  = 1'b0;
  assign carry_flag = 1'b0;
`endif

  // Operand fields are only presented while an ALU op is in flight
  assign alu_path   = (state == READ || state == EXEC || state == WB) && !instr_p0[15];
  assign ra_addr    = alu_path ? instr_p0[7:4]   : 4'd0;
  assign rb_addr    = alu_path ? instr_p0[3:0]   : 4'd0;
  assign alu_opcode = alu_path ? instr_p0[14:12] : 3'd0;

  assign write_en   = (state == WB);
  assign write_addr = write_en ? instr_p0[11:8] : 4'd0;
  assign write_data = !write_en   ? '0 :
                      instr_p0[15] ? DATA_W'(instr_p0[7:0]) : result_p1;

  assign instr_ready = (state == IDLE);
  assign busy        = (state == READ) || (state == EXEC) || (state == WB) || (state == TRAP);
  assign done        = (state == WB);
  assign error       = (state == TRAP);
  assign halted      = (state == HALT);

endmodule
